// File: rtl/reg_bank_bus_sequencer_pkg.sv
// Shared encodings for the register-bank bus sequencer: command opcodes and controller states.
package reg_bank_bus_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLR   = 2'b10,
    OP_PRE   = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ_EN,
    ST_READ_CAP,
    ST_RSP,
    ST_PULSE
  } state_e;

endpackage

// File: rtl/reg_bank_bus_sequencer_reg_sel_decoder.sv
// Address to one-hot register select, gated by an enable; flags addresses beyond the bank.
module reg_sel_decoder #(
  parameter int NrOfRegs = 8,
  parameter int AddrBits = 3
) (
  input  logic [AddrBits-1:0] addr,
  input  logic                enable,
  output logic [NrOfRegs-1:0] sel,
  output logic                out_of_range
);

  always_comb begin
    sel          = '0;
    out_of_range = enable && (32'(addr) >= NrOfRegs);
    for (int i = 0; i < NrOfRegs; i++) begin
      if (enable && (32'(addr) == i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_bus_sequencer.sv
// Upstream controller for a shared-bus register bank: sequences one read/write/clear/preset
// command at a time and returns read data over a valid/ready response channel.
module reg_bank_bus_sequencer
  import reg_bank_bus_sequencer_pkg::*;
#(
  parameter int NrOfRegs = 8,
  parameter int NrOfBits = 8,
  parameter int AddrBits = 3
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Tick,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [AddrBits-1:0] cmd_addr,
  input  logic [NrOfBits-1:0] cmd_wdata,
  output logic [NrOfRegs-1:0] reg_ce,
  output logic [NrOfRegs-1:0] reg_cs,
  output logic [NrOfRegs-1:0] reg_clr,
  output logic [NrOfRegs-1:0] reg_pre,
  output logic [NrOfBits-1:0] bus_d,
  input  logic [NrOfBits-1:0] bus_q,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NrOfBits-1:0] rsp_data,
  output logic                rsp_err,
  output logic                busy
);

  state_e              state;
  op_e                 op_in;
  logic                accept;
  logic                addr_err;
  logic [NrOfRegs-1:0] ce_sel, cs_sel, clr_sel, pre_sel;
  logic                ce_oob, cs_oob, clr_oob, pre_oob;

  assign op_in     = op_e'(cmd_op);
  assign cmd_ready = (state == ST_IDLE) && !Reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state != ST_IDLE);

  reg_sel_decoder #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_ce_dec (
    .addr(cmd_addr), .enable(op_in == OP_WRITE), .sel(ce_sel), .out_of_range(ce_oob));

  reg_sel_decoder #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_cs_dec (
    .addr(cmd_addr), .enable(op_in == OP_READ), .sel(cs_sel), .out_of_range(cs_oob));

  reg_sel_decoder #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_clr_dec (
    .addr(cmd_addr), .enable(op_in == OP_CLR), .sel(clr_sel), .out_of_range(clr_oob));

  reg_sel_decoder #(.NrOfRegs(NrOfRegs), .AddrBits(AddrBits)) u_pre_dec (
    .addr(cmd_addr), .enable(op_in == OP_PRE), .sel(pre_sel), .out_of_range(pre_oob));

  // Bank lines are loaded on the accepting edge so they are flop-driven from the first busy cycle.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      addr_err  <= 1'b0;
      reg_ce    <= '0;
      reg_cs    <= '1;
      reg_clr   <= '0;
      reg_pre   <= '0;
      bus_d     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            addr_err <= ce_oob | cs_oob | clr_oob | pre_oob;
            unique case (op_in)
              OP_WRITE: begin
                state  <= ST_WRITE;
                reg_ce <= ce_sel;
                bus_d  <= cmd_wdata;
              end
              OP_READ: begin
                state  <= ST_READ_EN;
                reg_cs <= ~cs_sel;
              end
              default: begin
                state   <= ST_PULSE;
                reg_clr <= clr_sel;
                reg_pre <= pre_sel;
              end
            endcase
          end
        end
        // An out-of-range write has nothing to wait for, so it leaves after one cycle.
        ST_WRITE: begin
          if (Tick || addr_err) begin
            state  <= ST_IDLE;
            reg_ce <= '0;
          end
        end
        ST_READ_EN: state <= ST_READ_CAP;
        ST_READ_CAP: begin
          rsp_data  <= addr_err ? '0 : bus_q;
          rsp_err   <= addr_err;
          rsp_valid <= 1'b1;
          reg_cs    <= '1;
          state     <= ST_RSP;
        end
        ST_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        ST_PULSE: begin
          reg_clr <= '0;
          reg_pre <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bank_bus_sequencer.sv
// Self-checking bench: a behavioural register bank sits on the buses while a command-level
// memory model predicts read data and the expected per-cycle bank strobes.
module tb_reg_bank_bus_sequencer;

  localparam int NrOfRegs = 8;
  localparam int NrOfBits = 8;
  localparam int AddrBits = 4;

  logic                Clock, Reset, Tick;
  logic                cmd_valid, cmd_ready;
  logic [1:0]          cmd_op;
  logic [AddrBits-1:0] cmd_addr;
  logic [NrOfBits-1:0] cmd_wdata;
  logic [NrOfRegs-1:0] reg_ce, reg_cs, reg_clr, reg_pre;
  logic [NrOfBits-1:0] bus_d, bus_q;
  logic                rsp_valid, rsp_ready, rsp_err, busy;
  logic [NrOfBits-1:0] rsp_data;

  int compared   = 0;
  int mismatched = 0;

  logic [NrOfBits-1:0] bank [NrOfRegs] = '{default: '0};
  logic [NrOfBits-1:0] mem  [NrOfRegs] = '{default: '0};

  reg_bank_bus_sequencer #(.NrOfRegs(NrOfRegs), .NrOfBits(NrOfBits), .AddrBits(AddrBits)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .reg_ce(reg_ce), .reg_cs(reg_cs), .reg_clr(reg_clr), .reg_pre(reg_pre),
    .bus_d(bus_d), .bus_q(bus_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .busy(busy));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Bank model: loads on ce&Tick, strobes are one full cycle wide; undriven bus floats high.
  always @(posedge Clock) begin
    for (int i = 0; i < NrOfRegs; i++) begin
      if (reg_clr[i])                bank[i] <= '0;
      else if (reg_pre[i])           bank[i] <= '1;
      else if (reg_ce[i] && Tick)    bank[i] <= bus_d;
    end
  end

  always_comb begin
    bus_q = '1;
    for (int i = 0; i < NrOfRegs; i++) if (!reg_cs[i]) bus_q = bank[i];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ce"}, reg_ce, 0);
    checkOutput({tag, "_cs"}, reg_cs, 8'hFF);
    checkOutput({tag, "_clr"}, reg_clr, 0);
    checkOutput({tag, "_pre"}, reg_pre, 0);
    checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Issues one command starting at a negedge and checks every cycle until the controller is idle again.
  task automatic applyStimulus(input logic [1:0] op, input logic [AddrBits-1:0] addr,
                               input logic [NrOfBits-1:0] wdata, input int tickDelay, input int rspHold);
    logic                oob;
    logic [NrOfRegs-1:0] sel, csExp;
    logic [NrOfBits-1:0] exp;
    int                  waitCnt;
    oob   = (int'(addr) >= NrOfRegs);
    sel   = oob ? '0 : NrOfRegs'(1 << addr);
    csExp = ~sel;
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_wdata = wdata; Tick = 1'($urandom);
    waitCnt = 0;
    while (!cmd_ready && waitCnt < 10) begin
      @(negedge Clock);
      waitCnt++;
    end
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    @(negedge Clock);
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AddrBits'($urandom); cmd_wdata = NrOfBits'($urandom);
    checkOutput("busy_first", busy, 1);
    checkOutput("cmd_ready_busy", cmd_ready, 0);
    case (op)
      2'b01: begin
        if (oob) begin
          checkOutput("ce_oob", reg_ce, 0);
          Tick = 1'b0;
          @(negedge Clock);
        end else begin
          for (int k = 0; k <= tickDelay; k++) begin
            checkOutput("ce_hold", reg_ce, sel);
            checkOutput("bus_d", bus_d, wdata);
            checkOutput("busy_write", busy, 1);
            checkOutput("cmd_ready_write", cmd_ready, 0);
            Tick = (k == tickDelay);
            @(negedge Clock);
          end
          mem[addr[2:0]] = wdata;
        end
        checkOutput("ce_done", reg_ce, 0);
      end
      2'b10, 2'b11: begin
        checkOutput("clr_pulse", reg_clr, (op == 2'b10) ? sel : '0);
        checkOutput("pre_pulse", reg_pre, (op == 2'b11) ? sel : '0);
        Tick = 1'($urandom);
        @(negedge Clock);
        checkOutput("clr_done", reg_clr, 0);
        checkOutput("pre_done", reg_pre, 0);
        if (!oob) mem[addr[2:0]] = (op == 2'b10) ? '0 : '1;
      end
      default: begin
        exp = oob ? '0 : mem[addr[2:0]];
        for (int k = 0; k < 2; k++) begin
          checkOutput("cs_read", reg_cs, csExp);
          checkOutput("rsp_early", rsp_valid, 0);
          Tick = 1'($urandom);
          @(negedge Clock);
        end
        checkOutput("rsp_valid", rsp_valid, 1);
        checkOutput("rsp_data", rsp_data, exp);
        checkOutput("rsp_err", rsp_err, oob);
        checkOutput("cs_release", reg_cs, 8'hFF);
        for (int k = 0; k < rspHold; k++) begin
          @(negedge Clock);
          checkOutput("rsp_hold_valid", rsp_valid, 1);
          checkOutput("rsp_hold_data", rsp_data, exp);
        end
        rsp_ready = 1'b1;
        @(negedge Clock);
        rsp_ready = 1'b0;
        checkOutput("rsp_done", rsp_valid, 0);
      end
    endcase
    checkOutput("busy_end", busy, 0);
  endtask

  initial begin
    logic [1:0] rop;
    Reset = 1'b1; Tick = 1'b1; rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 4'd1; cmd_wdata = 8'h77;
    repeat (3) @(negedge Clock);
    checkIdleOutputs("reset");
    checkOutput("reset_bus_d", bus_d, 0);
    checkOutput("reset_rsp_data", rsp_data, 0);
    checkOutput("reset_rsp_err", rsp_err, 0);
    checkOutput("reset_cmd_ready", cmd_ready, 0);
    Reset = 1'b0; cmd_valid = 1'b0;
    #1 checkOutput("release_cmd_ready", cmd_ready, 1);
    @(negedge Clock);

    applyStimulus(2'b01, 4'd3, 8'hA5, 0, 0);
    applyStimulus(2'b00, 4'd3, 8'h00, 0, 0);
    applyStimulus(2'b01, 4'd3, 8'h3C, 4, 0);
    applyStimulus(2'b00, 4'd3, 8'h00, 0, 1);
    applyStimulus(2'b10, 4'd5, 8'h00, 0, 0);
    applyStimulus(2'b11, 4'd2, 8'h00, 0, 0);
    applyStimulus(2'b00, 4'd2, 8'h00, 0, 0);
    applyStimulus(2'b00, 4'd9, 8'h00, 0, 0);
    applyStimulus(2'b01, 4'd12, 8'h5A, 2, 0);

    for (int n = 0; n < 60; n++) begin
      rop = 2'($urandom);
      applyStimulus(rop, AddrBits'($urandom_range(0, 9)), NrOfBits'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Pending response held off, then dropped by reset.
    applyStimulus(2'b01, 4'd6, 8'hC3, 0, 0);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'd6;
    checkOutput("rst_case_ready", cmd_ready, 1);
    @(negedge Clock);
    cmd_valid = 1'b0;
    repeat (2) @(negedge Clock);
    checkOutput("rst_case_valid", rsp_valid, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge Clock);
      checkOutput("rst_case_stable", rsp_data, 8'hC3);
    end
    Reset = 1'b1;
    #1;
    checkIdleOutputs("mid_reset");
    checkOutput("mid_reset_rsp_data", rsp_data, 0);
    @(negedge Clock);
    Reset = 1'b0;
    #1 checkOutput("after_reset_ready", cmd_ready, 1);
    @(negedge Clock);
    applyStimulus(2'b00, 4'd6, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
